// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM encoding and
// the start-to-done latency formula.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REDUCE,
    S_ITER,
    S_FIN
  } state_t;

  // Cycles from the acceptance edge to done, for k multiplier passes after REDUCE.
  function automatic int lat(input int k, input int w);
    return 2 + (k + 1) * (w + 1);
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m, one bit of a per
// cycle (MSB first), requires b < m and m >= 2.
module mod_mul_serial #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         rdy,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  // 2P + a_i*b < 3m, so at most two conditional subtractions bring it below m;
  // W+2 bits hold the intermediate without overflow.
  function automatic logic [W-1:0] mac_step(input logic [W-1:0] acc,
                                            input logic         bit_i,
                                            input logic [W-1:0] bv,
                                            input logic [W-1:0] mv);
    logic [W+1:0] t;
    logic [W+1:0] mx;
    mx = {2'b00, mv};
    t  = {1'b0, acc, 1'b0} + (bit_i ? {2'b00, bv} : '0);
    if (t >= mx) t = t - mx;
    if (t >= mx) t = t - mx;
    return t[W-1:0];
  endfunction

  always_comb begin
    p_d   = p_q;
    a_d   = a_q;
    b_d   = b_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    rdy_d = 1'b0;
    if (go) begin
      p_d   = '0;
      a_d   = a;
      b_d   = b;
      m_d   = m;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      p_d   = mac_step(p_q, a_q[W-1], b_q, m_q);
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      rdy_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  assign rdy = rdy_q;
  assign p   = p_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation built on two
// bit-serial modular multipliers, with start/busy/done handshake.
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WORDSIZE   = 8,
  parameter int EXP_WIDTH  = 2 * WORDSIZE,
  parameter int CONST_TIME = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*WORDSIZE-1:0]   base,
  input  logic [2*WORDSIZE-1:0]   modulo,
  input  logic [EXP_WIDTH-1:0]    exponent,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2*WORDSIZE-1:0]   result
);

  localparam int W  = 2 * WORDSIZE;
  localparam int CW = $clog2(EXP_WIDTH + 1);

  state_t               state_q, state_d;
  logic [W-1:0]         base_q, base_d;
  logic [W-1:0]         mod_q, mod_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [W-1:0]         res_q, res_d;
  logic [W-1:0]         base_r_q, base_r_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 error_q, error_d;
  logic [W-1:0]         result_q, result_d;
  logic                 last;

  logic         go_a, go_b, rdy_a, rdy_b;
  logic [W-1:0] a_a, b_a, a_b, b_b, p_a, p_b;

  mod_mul_serial #(.W(W)) u_mul_a (
    .clk   (clk),
    .reset (reset),
    .go    (go_a),
    .a     (a_a),
    .b     (b_a),
    .m     (mod_q),
    .rdy   (rdy_a),
    .p     (p_a)
  );

  mod_mul_serial #(.W(W)) u_mul_b (
    .clk   (clk),
    .reset (reset),
    .go    (go_b),
    .a     (a_b),
    .b     (b_b),
    .m     (mod_q),
    .rdy   (rdy_b),
    .p     (p_b)
  );

  // Multipliers are launched on the edge that enters each phase, using the
  // freshly updated operands, so every phase is exactly W+1 cycles.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    mod_d    = mod_q;
    exp_d    = exp_q;
    res_d    = res_q;
    base_r_d = base_r_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    result_d = result_q;
    last     = 1'b0;
    go_a     = 1'b0;
    go_b     = 1'b0;
    a_a      = '0;
    b_a      = '0;
    a_b      = '0;
    b_b      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base;
          mod_d    = modulo;
          exp_d    = exponent;
          cnt_d    = '0;
          error_d  = 1'b0;
          result_d = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mod_q == '0) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = S_FIN;
        end else if (mod_q == W'(1)) begin
          result_d = '0;
          state_d  = S_FIN;
        end else begin
          res_d   = W'(1);
          go_a    = 1'b1;
          a_a     = base_q;
          b_a     = W'(1);
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (rdy_a) begin
          base_r_d = p_a;
          if (CONST_TIME == 0 && exp_q == '0) begin
            result_d = res_q;
            state_d  = S_FIN;
          end else begin
            go_a    = 1'b1;
            go_b    = 1'b1;
            a_a     = res_q;
            b_a     = p_a;
            a_b     = p_a;
            b_b     = p_a;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        if (rdy_a && rdy_b) begin
          res_d    = exp_q[0] ? p_a : res_q;
          base_r_d = p_b;
          exp_d    = exp_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (CONST_TIME != 0) last = (cnt_q == CW'(EXP_WIDTH - 1));
          else                 last = (exp_d == '0);
          if (last) begin
            result_d = res_d;
            state_d  = S_FIN;
          end else begin
            go_a = 1'b1;
            go_b = 1'b1;
            a_a  = res_d;
            b_a  = p_b;
            a_b  = p_b;
            b_b  = p_b;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      res_q    <= '0;
      base_r_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      exp_q    <= exp_d;
      res_q    <= res_d;
      base_r_q <= base_r_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CHECK) || (state_q == S_REDUCE) || (state_q == S_ITER);
  assign done   = (state_q == S_FIN);
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine (W=16): one instance in early-exit mode,
// one in constant-time mode, sharing clock, reset and operand buses.
module tb_mod_exp_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] base = '0, modulo = '0, exponent = '0;
  logic        busy0, done0, error0, busy1, done1, error1;
  logic [15:0] result0, result1;

  int ncmp = 0;
  int nfail = 0;
  int ecnt = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  mod_exp_engine #(.WORDSIZE(8), .EXP_WIDTH(16), .CONST_TIME(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .base(base), .modulo(modulo),
    .exponent(exponent), .busy(busy0), .done(done0), .error(error0), .result(result0)
  );

  mod_exp_engine #(.WORDSIZE(8), .EXP_WIDTH(16), .CONST_TIME(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base(base), .modulo(modulo),
    .exponent(exponent), .busy(busy1), .done(done1), .error(error1), .result(result1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    ncmp++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                             input logic [15:0] m);
    longint unsigned r, x, mm;
    mm = longint'(m);
    r  = 1;
    x  = longint'(b) % mm;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return 16'(r);
  endfunction

  // Waits for the chosen engine to be idle, pulses start for one edge and
  // records the acceptance edge with the expected response.
  task automatic issue(input int d, input logic [15:0] b, input logic [15:0] m,
                       input logic [15:0] e, input logic [15:0] xr, input logic xe,
                       input int xlat);
    int   g;
    exp_t x;
    g = 0;
    @(negedge clk);
    while (((d == 0) ? (busy0 || done0) : (busy1 || done1)) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      ncmp++;
      nfail++;
      $display("FAIL issue_wait: engine %0d still busy after %0d cycles", d, g);
    end else begin
      base = b;
      modulo = m;
      exponent = e;
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      x.res = xr;
      x.err = xe;
      x.lat = xlat;
      x.acc = ecnt;
      if (d == 0) sb0.push_back(x); else sb1.push_back(x);
    end
  endtask

  task automatic drain(input int d);
    int g;
    g = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      ncmp++;
      nfail++;
      $display("FAIL drain: engine %0d produced no done within %0d cycles", d, g);
    end
    @(negedge clk);
  endtask

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!reset && done0) begin
      if (sb0.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL dut0_unexpected_done: got result %0d, required no done", result0);
      end else begin
        exp_t x;
        x = sb0.pop_front();
        chk("dut0_result", result0, x.res);
        chk("dut0_error", error0, x.err);
        chk("dut0_latency", ecnt - x.acc + 1, x.lat);
      end
    end
    if (!reset && done1) begin
      if (sb1.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL dut1_unexpected_done: got result %0d, required no done", result1);
      end else begin
        exp_t x;
        x = sb1.pop_front();
        chk("dut1_result", result1, x.res);
        chk("dut1_error", error1, x.err);
        chk("dut1_latency", ecnt - x.acc + 1, x.lat);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", ncmp);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_error0", error0, 0);
    chk("rst_result0", result0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_result1", result1, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 4^13 mod 497 with busy window checks
    issue(0, 16'd4, 16'd497, 16'd13, 16'd445, 1'b0, 87);
    chk("t1_busy_c1", busy0, 1);
    repeat (85) @(posedge clk);
    #1;
    chk("t1_busy_c86", busy0, 1);
    chk("t1_done_c86", done0, 0);
    @(posedge clk);
    #1;
    chk("t1_busy_c87", busy0, 0);
    drain(0);

    // reset while idle clears a held result
    chk("held_result", result0, 445);
    #2 reset = 1'b1;
    #1;
    chk("idle_rst_result", result0, 0);
    chk("idle_rst_busy", busy0, 0);
    @(negedge clk);
    reset = 1'b0;

    // RSA pair, back-to-back
    issue(0, 16'd65, 16'd3233, 16'd17, 16'd2790, 1'b0, 104);
    issue(0, 16'd2790, 16'd3233, 16'd2753, 16'd65, 1'b0, 223);
    drain(0);

    // over-range base, both timing modes
    issue(0, 16'd1000, 16'd7, 16'd3, 16'd6, 1'b0, 53);
    issue(1, 16'd1000, 16'd7, 16'd3, 16'd6, 1'b0, 291);
    drain(0);
    drain(1);

    // degenerate moduli and zero exponent
    issue(0, 16'd123, 16'd0, 16'd5, 16'd0, 1'b1, 2);
    issue(0, 16'd123, 16'd1, 16'd5, 16'd0, 1'b0, 2);
    issue(0, 16'd5, 16'd11, 16'd0, 16'd1, 1'b0, 19);
    issue(1, 16'd77, 16'd0, 16'd9, 16'd0, 1'b1, 2);
    issue(1, 16'd5, 16'd11, 16'd0, 16'd1, 1'b0, 291);
    drain(0);
    drain(1);

    // reset in cycle 40 of a run aborts it without a done pulse
    issue(0, 16'd4, 16'd497, 16'd13, 16'd445, 1'b0, 87);
    repeat (39) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_result", result0, 0);
    void'(sb0.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    issue(0, 16'd4, 16'd497, 16'd13, 16'd445, 1'b0, 87);
    drain(0);

    // start while busy is ignored
    issue(0, 16'd65, 16'd3233, 16'd17, 16'd2790, 1'b0, 104);
    repeat (8) @(posedge clk);
    @(negedge clk);
    base = 16'd9;
    modulo = 16'd100;
    exponent = 16'd3;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("ignored_start_busy", busy0, 1);
    drain(0);

    // random operands against the reference model
    for (int i = 0; i < 120; i++) begin
      logic [15:0] rb, rm, re;
      int k;
      rb = 16'($urandom);
      rm = 16'($urandom_range(65535, 2));
      re = 16'($urandom);
      re = re >> $urandom_range(15, 0);
      k = 0;
      for (int j = 0; j < 16; j++) if (re[j]) k = j + 1;
      issue(0, rb, rm, re, ref_modexp(rb, re, rm), 1'b0, 2 + (k + 1) * 17);
    end
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
